// File: rtl/galaga_input_ctrl.sv
// galaga_input_ctrl: PS/2 key state and HPS joystick merge into galaga control lines, with spaced coin pulses.
module galaga_input_ctrl #(
  parameter logic [15:0] COIN_PULSE = 16'd1800,
  parameter logic [15:0] COIN_GAP   = 16'd1800,
  parameter int          COIN_QMAX  = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        no_rotate,
  input  logic        clear,
  output logic        start1,
  output logic        start2,
  output logic        left1,
  output logic        right1,
  output logic        fire1,
  output logic        left2,
  output logic        right2,
  output logic        fire2,
  output logic        coin,
  output logic [2:0]  coin_pending
);
  localparam int K_UP = 0, K_DN = 1, K_LT = 2, K_RT = 3, K_FIRE = 4, K_F1 = 5, K_F2 = 6, K_1 = 7;
  localparam int K_2 = 8, K_5 = 9, K_6 = 10, K_R = 11, K_F = 12, K_D = 13, K_G = 14, K_A = 15;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t      state_q, state_d;
  logic        tog_q, req_q, coin_q, coin_d, ev, inc, dec, coin_req, unused_j;
  logic [15:0] key_q, key_d, sel, j, timer_q, timer_d;
  logic [7:0]  ctl_q, ctl_d;
  logic [8:0]  code;
  logic [2:0]  pend_q, pend_d;
  assign j        = joystick_0 | joystick_1;
  assign unused_j = ^j[15:7];
  assign code     = ps2_key[8:0];
  assign ev       = ps2_key[10] ^ tog_q;
  always_comb begin
    sel         = '0;
    sel[K_UP]   = code[7:0] == 8'h75;
    sel[K_DN]   = code[7:0] == 8'h72;
    sel[K_LT]   = code[7:0] == 8'h6B;
    sel[K_RT]   = code[7:0] == 8'h74;
    sel[K_FIRE] = code == 9'h029 || code == 9'h014;
    sel[K_F1]   = code == 9'h005;
    sel[K_F2]   = code == 9'h006;
    sel[K_1]    = code == 9'h016;
    sel[K_2]    = code == 9'h01E;
    sel[K_5]    = code == 9'h02E;
    sel[K_6]    = code == 9'h036;
    sel[K_R]    = code == 9'h02D;
    sel[K_F]    = code == 9'h02B;
    sel[K_D]    = code == 9'h023;
    sel[K_G]    = code == 9'h034;
    sel[K_A]    = code == 9'h01C;
    key_d       = ev ? (key_q & ~sel) | (sel & {16{ps2_key[9]}}) : key_q;
  end
  // ctl order: start1 start2 left1 right1 fire1 left2 right2 fire2
  always_comb begin
    ctl_d[7] = key_q[K_F1] | key_q[K_1] | j[5];
    ctl_d[6] = key_q[K_F2] | key_q[K_2] | j[6];
    ctl_d[5] = no_rotate ? key_q[K_DN] | j[2] : key_q[K_LT] | j[1];
    ctl_d[4] = no_rotate ? key_q[K_UP] | j[3] : key_q[K_RT] | j[0];
    ctl_d[3] = key_q[K_FIRE] | j[4];
    ctl_d[2] = no_rotate ? key_q[K_F] | j[2] : key_q[K_D] | j[1];
    ctl_d[1] = no_rotate ? key_q[K_R] | j[3] : key_q[K_G] | j[0];
    ctl_d[0] = key_q[K_A] | j[4];
  end
  assign coin_req = ctl_q[7] | ctl_q[6] | key_q[K_5] | key_q[K_6];
  assign inc      = coin_req & ~req_q;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    case (state_q)
      IDLE: if (pend_q != 3'd0) begin
        state_d = PULSE;
        timer_d = COIN_PULSE - 16'd1;
        dec     = 1'b1;
      end
      PULSE: begin
        state_d = timer_q == 16'd0 ? GAP : PULSE;
        timer_d = timer_q == 16'd0 ? COIN_GAP - 16'd1 : timer_q - 16'd1;
      end
      GAP: begin
        state_d = timer_q == 16'd0 ? IDLE : GAP;
        timer_d = timer_q == 16'd0 ? 16'd0 : timer_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    pend_d = (inc && !dec && pend_q != 3'(COIN_QMAX)) ? pend_q + 3'd1 :
             (dec && !inc) ? pend_q - 3'd1 : pend_q;
    coin_d = state_d == PULSE;
  end
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (!reset_n || clear) begin
      key_q   <= '0;
      ctl_q   <= '0;
      req_q   <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      coin_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      ctl_q   <= ctl_d;
      req_q   <= coin_req;
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      coin_q  <= coin_d;
    end
  end
  assign {start1, start2, left1, right1, fire1, left2, right2, fire2} = ctl_q;
  assign coin         = coin_q;
  assign coin_pending = pend_q;
endmodule

// File: tb/tb_galaga_input_ctrl.sv
// tb_galaga_input_ctrl: directed checks of key decode, joystick merge, rotation, coin queue, clear and reset.
module tb_galaga_input_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset_n, no_rotate, clear;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        start1, start2, left1, right1, fire1, left2, right2, fire2, coin;
  logic [2:0]  coin_pending;
  int          checks = 0, errors = 0;
  int          pulses, hi_total, cur_len, lo_len, bad_len, bad_gap, max_pend;
  logic        prev_coin;

  galaga_input_ctrl #(.COIN_PULSE(16'd4), .COIN_GAP(16'd3), .COIN_QMAX(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick_0(joystick_0),
    .joystick_1(joystick_1), .no_rotate(no_rotate), .clear(clear), .start1(start1),
    .start2(start2), .left1(left1), .right1(right1), .fire1(fire1), .left2(left2),
    .right2(right2), .fire2(fire2), .coin(coin), .coin_pending(coin_pending));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clr();
    pulses = 0; hi_total = 0; cur_len = 0; lo_len = 100; bad_len = 0; bad_gap = 0; max_pend = 0;
    prev_coin = 1'b0;
  endtask

  task automatic step();
    @(negedge clk_sys);
    if (coin) begin
      if (!prev_coin) begin
        if (pulses > 0 && lo_len < 3) bad_gap++;
        pulses++;
        cur_len = 0;
      end
      cur_len++;
      hi_total++;
    end else begin
      if (prev_coin) begin
        if (cur_len != 4) bad_len++;
        lo_len = 0;
      end
      lo_len++;
    end
    if (int'(coin_pending) > max_pend) max_pend = int'(coin_pending);
    prev_coin = coin;
  endtask

  task automatic send(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  function automatic logic [10:0] outs();
    return {start1, start2, left1, right1, fire1, left2, right2, fire2, coin, coin_pending};
  endfunction

  initial begin
    reset_n = 1'b0; no_rotate = 1'b0; clear = 1'b0; ps2_key = '0;
    joystick_0 = '0; joystick_1 = '0;
    mon_clr();
    step(); step();
    chk("reset_outs", 16'(outs()), 16'h0);
    reset_n = 1'b1;
    step();
    chk("post_reset_outs", 16'(outs()), 16'h0);
    // Space make: fire1 two clocks after the toggle flips
    send(1'b1, 9'h029);
    step(); chk("space_1clk", 16'(fire1), 16'h0);
    step(); chk("space_2clk", 16'(fire1), 16'h1);
    send(1'b0, 9'h014);
    step(); chk("ctrl_brk_1clk", 16'(fire1), 16'h1);
    step(); chk("ctrl_brk_2clk", 16'(fire1), 16'h0);
    // A and D keys, vertical orientation
    send(1'b1, 9'h01C); step();
    send(1'b1, 9'h023); step(); step();
    chk("a_d_keys", {14'h0, left2, fire2}, 16'h3);
    send(1'b0, 9'h01C); step();
    send(1'b0, 9'h023); step(); step();
    chk("a_d_release", {14'h0, left2, fire2}, 16'h0);
    // joystick merge and rotation
    joystick_1 = 16'h0002; step();
    chk("joy1_left", {14'h0, left1, right1}, 16'h2);
    joystick_1 = 16'h0000; joystick_0 = 16'h0008; no_rotate = 1'b1; step();
    chk("joy0_rot_right", {14'h0, left1, right1}, 16'h1);
    chk("joy0_rot_right2", 16'(right2), 16'h1);
    joystick_0 = 16'h0000; no_rotate = 1'b0; step(); step();
    chk("idle_outs", 16'(outs()), 16'h0);
    // single '5' tap
    mon_clr();
    send(1'b1, 9'h02E);
    for (int i = 0; i < 10; i++) step();
    send(1'b0, 9'h02E);
    for (int i = 0; i < 30; i++) step();
    chk("tap_pulses", 16'(pulses), 16'd1);
    chk("tap_high", 16'(hi_total), 16'd4);
    chk("tap_maxpend", 16'(max_pend), 16'd1);
    chk("tap_pend_end", 16'(coin_pending), 16'd0);
    // five quick taps: queue saturates at 3, four pulses total
    mon_clr();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 9'h02E); step();
      send(1'b0, 9'h02E); step();
    end
    for (int i = 0; i < 60; i++) step();
    chk("q_pulses", 16'(pulses), 16'd4);
    chk("q_maxpend", 16'(max_pend), 16'd3);
    chk("q_bad_len", 16'(bad_len), 16'd0);
    chk("q_bad_gap", 16'(bad_gap), 16'd0);
    chk("q_high", 16'(hi_total), 16'd16);
    chk("q_pend_end", 16'(coin_pending), 16'd0);
    // clear during a pulse with two coins pending and Space held
    send(1'b1, 9'h029); step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 9'h02E); step();
      send(1'b0, 9'h02E); step();
    end
    chk("pre_clear_coin", {12'h0, coin, coin_pending}, 16'hA);
    chk("pre_clear_fire", 16'(fire1), 16'h1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_outs", 16'(outs()), 16'h0);
    mon_clr();
    for (int i = 0; i < 20; i++) step();
    chk("clear_no_pulse", 16'(pulses), 16'd0);
    chk("clear_fire_off", 16'(fire1), 16'h0);
    // extended arrow and ignored right Ctrl
    no_rotate = 1'b1;
    send(1'b1, 9'h175); step(); step();
    chk("ext_up_right1", 16'(right1), 16'h1);
    send(1'b1, 9'h114); step(); step();
    chk("rctrl_ignored", 16'(fire1), 16'h0);
    no_rotate = 1'b0; step();
    chk("unrot_hold", {14'h0, left1, right1}, 16'h0);
    no_rotate = 1'b1; step();
    chk("rerot_hold", {14'h0, left1, right1}, 16'h1);
    reset_n = 1'b0; step();
    chk("reset_held_outs", 16'(outs()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
